// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32/64 M-extension multiply/divide unit.
// Multiply is shift-add, divide is restoring division; both retire one bit
// per CALC cycle and share a single 2*XLEN-bit accumulator. Divide-by-zero
// and signed overflow skip the iteration and go straight to DONE.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [6:0]      CNT_INIT = 7'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [2:0]        op;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic [6:0]        cnt;
    logic              neg_res;
    logic              neg_rem;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, fast;
    logic [XLEN-1:0]   fast_result;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   calc_result;

    // Decode the incoming request: operand signs, magnitudes and the fast-path cases.
    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed & srcA[XLEN-1];
        b_neg    = b_signed & srcB[XLEN-1];
        mag_a    = a_neg ? -srcA : srcA;
        mag_b    = b_neg ? -srcB : srcB;
        div_zero = funct3[2] && (srcB == '0);
        div_ovf  = funct3[2] && !funct3[0] && (srcA == INT_MIN) && (srcB == '1);
        fast     = div_zero || div_ovf;
        if (div_zero) begin
            fast_result = funct3[1] ? srcA : '1;
        end else begin
            fast_result = funct3[1] ? '0 : srcA;
        end
    end

    // One iteration step plus sign correction of the value it would produce.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd};
        if (op[2]) begin
            if (div_diff[XLEN]) begin
                acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
        prod_fix = neg_res ? -acc_next : acc_next;
        quo_fix  = neg_res ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem_fix  = neg_rem ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        case (op)
            3'b000:                 calc_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         calc_result = quo_fix;
            default:                calc_result = rem_fix;
        endcase
    end

    // Control FSM, operand capture, iteration and result register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            op      <= 3'b000;
            opnd    <= '0;
            acc     <= '0;
            cnt     <= 7'd0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op      <= funct3;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        cnt     <= CNT_INIT;
                        if (fast) begin
                            result <= fast_result;
                            state  <= S_DONE;
                        end else begin
                            state <= S_CALC;
                            if (funct3[2]) begin
                                opnd <= mag_b;
                                acc  <= {{XLEN{1'b0}}, mag_a};
                            end else begin
                                opnd <= mag_a;
                                acc  <= {{XLEN{1'b0}}, mag_b};
                            end
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_next;
                        if (cnt == 7'd0) begin
                            result <= calc_result;
                            state  <= S_DONE;
                        end else begin
                            cnt <= cnt - 7'd1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE) && !flush;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: checks muldiv_unit (XLEN=32) against a cycle-level
// behavioural model plus directed literal cases, then random traffic.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        ready;
    logic        done;
    logic [31:0] result;

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 1'b0;

    // Behavioural model state: busy countdown, done cycle flag, held result.
    bit          m_busy    = 1'b0;
    bit          m_in_done = 1'b0;
    int          m_remain  = 0;
    logic [31:0] m_result  = '0;
    logic [31:0] m_pending = '0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .funct3  (funct3),
        .srcA    (srcA),
        .srcB    (srcB),
        .flush   (flush),
        .ready   (ready),
        .done    (done),
        .result  (result)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Architectural result of one M-extension operation.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic [31:0] r;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit ref_fast(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
        return f[2] && ((b == 0) ||
               (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Model: an accepted op completes XLEN edges later (fast path: at once).
    always @(posedge clk) begin
        if (!reset_n) begin
            m_busy    = 1'b0;
            m_in_done = 1'b0;
            m_result  = '0;
        end else if (m_in_done) begin
            m_in_done = 1'b0;
        end else if (m_busy) begin
            if (flush) begin
                m_busy = 1'b0;
            end else begin
                m_remain--;
                if (m_remain == 0) begin
                    m_busy    = 1'b0;
                    m_in_done = 1'b1;
                    m_result  = m_pending;
                end
            end
        end else if (start && !flush) begin
            m_pending = ref_op(funct3, srcA, srcB);
            if (ref_fast(funct3, srcA, srcB)) begin
                m_in_done = 1'b1;
                m_result  = m_pending;
            end else begin
                m_busy   = 1'b1;
                m_remain = XLEN;
            end
        end
    end

    // Compare every cycle, half a period after the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("ready", 64'(ready), 64'(!(m_busy || m_in_done)));
            checkOutput("done", 64'(done), 64'(m_in_done && !flush));
            checkOutput("result", 64'(result), 64'(m_result));
        end
    end

    // Drive one start cycle; caller is positioned between edges.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
        start  = 1'b1;
        funct3 = f;
        srcA   = a;
        srcB   = b;
        @(posedge clk);
        #2;
        start  = 1'b0;
        funct3 = 3'($urandom);
        srcA   = $urandom;
        srcB   = $urandom;
    endtask

    task automatic waitDone(output int cyc);
        cyc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = k + 1;
                break;
            end
        end
    endtask

    task automatic runOp(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
        int cyc;
        applyStimulus(f, a, b);
        waitDone(cyc);
        checkOutput({name, " result"}, 64'(result), 64'(exp));
        checkOutput({name, " latency"}, 64'(cyc), 64'(exp_cyc));
        @(negedge clk);
        checkOutput({name, " pulse width"}, 64'(done), 64'd0);
        checkOutput({name, " ready after"}, 64'(ready), 64'd1);
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        funct3  = 3'b000;
        srcA    = '0;
        srcB    = '0;
        repeat (3) @(posedge clk);
        #2;
        reset_n  = 1'b1;
        check_en = 1'b1;
        @(negedge clk);
        checkOutput("reset ready", 64'(ready), 64'd1);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset result", 64'(result), 64'd0);

        checkOutput("model MULH", 64'(ref_op(3'd1, 32'h8000_0000, 32'h8000_0000)), 64'h4000_0000);
        checkOutput("model MULHSU", 64'(ref_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFF);
        checkOutput("model REM", 64'(ref_op(3'd6, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFF);
        checkOutput("model DIV", 64'(ref_op(3'd4, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFD);
        @(posedge clk);
        #2;

        runOp("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        runOp("MULH", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        runOp("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        runOp("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        runOp("DIVU by 0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        runOp("REMU by 0", 3'd7, 32'd5, 32'd0, 32'h0000_0005, 1);
        runOp("DIV overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        runOp("REM overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        runOp("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        runOp("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);

        // Flush a DIV so that flush is sampled at edge N+10.
        applyStimulus(3'd4, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #2;
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush ready", 64'(ready), 64'd1);
        checkOutput("flush no done", 64'(done), 64'd0);
        checkOutput("flush result held", 64'(result), 64'hFFFF_FFFD);
        runOp("MUL after flush", 3'd0, 32'd12345, 32'd678, 32'd8369910, 33);

        // Reset sampled at edge N+5 of a MUL.
        applyStimulus(3'd0, 32'd123, 32'd456);
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("mid reset ready", 64'(ready), 64'd1);
        checkOutput("mid reset result", 64'(result), 64'd0);
        checkOutput("mid reset done", 64'(done), 64'd0);
        runOp("MUL after reset", 3'd0, 32'd123, 32'd456, 32'd56088, 33);

        // Flush beats a simultaneous start in IDLE.
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'd0;
        srcA   = 32'd3;
        srcB   = 32'd4;
        @(posedge clk);
        #2;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush priority ready", 64'(ready), 64'd1);
        @(posedge clk);
        #2;

        // Start held through CALC and DONE yields exactly one done.
        dones  = 0;
        start  = 1'b1;
        funct3 = 3'd0;
        srcA   = 32'd9;
        srcB   = 32'd11;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                break;
            end
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checkOutput("held start done count", 64'(dones), 64'd1);
        checkOutput("held start result", 64'(result), 64'd99);

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #2;
            start   = ($urandom % 3) == 0;
            flush   = ($urandom % 50) == 0;
            reset_n = ($urandom % 600) != 0;
            funct3  = 3'($urandom);
            srcA    = pick_operand();
            srcB    = pick_operand();
        end
        @(posedge clk);
        #2;
        start   = 1'b0;
        flush   = 1'b0;
        reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width in bits (legal values: 8, 16, 32 or 64).
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock, with all state updating on its rising edge.
REQ-003 Port reset_n SHALL be an input, 1 bit wide: synchronous, active-low reset.
REQ-004 Port start SHALL be an input, 1 bit wide: request to begin an operation, accepted only when ready=1.
REQ-005 Port funct3 SHALL be an input, 3 bits wide, with the RV M-extension encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port srcA SHALL be an input, XLEN bits wide: multiplicand or dividend.
REQ-007 Port srcB SHALL be an input, XLEN bits wide: multiplier or divisor.
REQ-008 Port flush SHALL be an input, 1 bit wide: abort any in-flight operation.
REQ-009 Port ready SHALL be an output, 1 bit wide: high when the unit can accept start.
REQ-010 Port done SHALL be an output, 1 bit wide: single-cycle pulse indicating that result is valid.
REQ-011 Port result SHALL be an output, XLEN bits wide: the registered result, held until the next accepted start.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE, with ready=1 only in IDLE.
REQ-013 In IDLE with start=1 and flush=0, the unit SHALL latch funct3, the operand magnitudes and the result sign flags; start in any other state SHALL be ignored.
REQ-014 Operand signedness SHALL be: MULH treats A and B as signed; MULHSU treats A as signed and B as unsigned; MULHU, DIVU and REMU treat both as unsigned; DIV and REM treat both as signed; MUL ignores signedness because only the low half is used.
REQ-015 Multiply SHALL use shift-add with one multiplier bit per CALC cycle, exactly XLEN CALC cycles, and a 2*XLEN-bit product accumulator.
REQ-016 Divide SHALL use restoring division with one quotient bit per CALC cycle, exactly XLEN CALC cycles.
REQ-017 The final sign correction SHALL be: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the sign of the dividend.
REQ-018 Result selection SHALL be: MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2XLEN-1:XLEN]; DIV and DIVU return the quotient; REM and REMU return the remainder.
REQ-019 The normal-path latency SHALL be: start sampled at edge N, done=1 during cycle N+XLEN+1, and ready=1 again at cycle N+XLEN+2.
REQ-020 Divide-by-zero (srcB=0) SHALL take a fast path from IDLE directly to DONE, with done=1 in cycle N+1; DIV and DIVU return all ones, and REM and REMU return srcA.
REQ-021 Signed overflow (DIV or REM with srcA=2^(XLEN-1) and srcB=all ones) SHALL take the fast path; DIV returns srcA and REM returns 0.
REQ-022 A 5-bit-or-wider iteration counter SHALL count XLEN-1 down to 0, with CALC exiting to DONE on the cycle the counter equals 0.
REQ-023 DONE SHALL last exactly one cycle, drive done=1, and then return to IDLE.
REQ-024 flush=1 in CALC or DONE SHALL force IDLE at the next edge with no done pulse and result unchanged.
REQ-025 flush=1 in IDLE SHALL take priority over a simultaneous start, so that no operation is accepted.
REQ-026 start asserted together with done (i.e. in the DONE state) SHALL be ignored; a back-to-back operation requires start in the following IDLE cycle.
REQ-027 Inputs funct3, srcA and srcB SHALL be sampled only at acceptance, so changes during CALC have no effect.

Reset
REQ-028 On reset_n=0 sampled at a clk edge, the state SHALL become IDLE, with ready=1, done=0, result=0, and the counter and accumulators cleared.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no done pulse, and the unit SHALL accept start in the first cycle after reset_n=1.

Verification (XLEN=32)
REQ-030 MUL with srcA=7 and srcB=0xFFFFFFFD -> result=0xFFFFFFEB, done at cycle N+33, single-cycle pulse.
REQ-031 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 0x00000005, with done at N+1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+1.
REQ-033 REM 0xFFFFFFF9/2 -> 0xFFFFFFFF and DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD, with done at N+33.
REQ-034 flush at cycle N+10 of a DIV -> no done, ready=1 at N+11; a new MUL started at N+11 completes correctly.
REQ-035 reset_n=0 at cycle N+5 of a MUL -> ready=1, result=0, no done; start held high during CALC -> ignored, with exactly one done per accepted start.
